// File: rtl/bcd_display_mux_if.sv
// Digit-source / display-pin bundle for bcd_display_mux.
// The master drives the BCD digits, dp requests and load strobe; the slave drives the display pins.
interface bcd_display_mux_if;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic        load;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        dp;

   modport master (output digits, dp_in, load, input anode, seg, dp);
   modport slave  (input digits, dp_in, load, output anode, seg, dp);
endinterface

// File: rtl/bcd_display_mux.sv
// Snapshots four BCD digits on load and scans them onto a 4-digit common-anode display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zeros on digits 3..1).
module bcd_display_mux #(
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic            clk,
   input  logic            reset,
   bcd_display_mux_if.slave bus
);
   localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [3:0][3:0] snap_q, snap_d;
   logic [3:0]      dps_q, dps_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0]      anode_q, anode_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [3:0]      cur_digit;
   logic            blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

`ifdef LEADING_ZERO_BLANK_EN
   // blank_mask[i]: digit i and every more-significant digit are zero; digit0 never blanks
   logic [3:0] blank_mask;
   always_comb begin
      blank_mask[3] = (snap_q[3] == 4'd0);
      blank_mask[2] = blank_mask[3] && (snap_q[2] == 4'd0);
      blank_mask[1] = blank_mask[2] && (snap_q[1] == 4'd0);
      blank_mask[0] = 1'b0;
      blank         = blank_mask[idx_q];
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      snap_d    = bus.load ? bus.digits : snap_q;
      dps_d     = bus.load ? bus.dp_in  : dps_q;
      presc_d   = presc_q + PW'(1);
      idx_d     = idx_q;
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end
      // Outputs come only from registered state, so a load never tears a lit digit
      cur_digit = snap_q[idx_q];
      anode_d   = ~(4'b0001 << idx_q);
      seg_d     = blank ? 7'b1111111 : seg_decode(cur_digit);
      dp_d      = ~dps_q[idx_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q  <= '0;
         dps_q   <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         anode_q <= 4'b1110;
         seg_q   <= 7'b1000000;
         dp_q    <= 1'b1;
      end else begin
         snap_q  <= snap_d;
         dps_q   <= dps_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign bus.anode = anode_q;
   assign bus.seg   = seg_q;
   assign bus.dp    = dp_q;
endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench for bcd_display_mux at REFRESH_DIV=4: stimulus pushes expected pins per edge,
// a negedge monitor pops and compares.
module tb_bcd_display_mux;
   localparam int RD = 4;

   typedef struct {
      logic [3:0] an;
      logic [6:0] sg;
      logic       dp;
      string      name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // expected-state bookkeeping: edges since reset and the snapshot the display should hold
   int          k = 0;
   logic [15:0] e_snap = '0;
   logic [3:0]  e_dps = '0;

   bcd_display_mux_if bus();

   bcd_display_mux #(.REFRESH_DIV(RD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #10 clk = ~clk;

   function automatic logic [6:0] exp_seg(input logic [15:0] s, input int idx);
      logic [3:0] d;
      logic       all_zero;
      d = s[idx*4 +: 4];
      all_zero = 1'b1;
      for (int j = idx; j < 4; j++) if (s[j*4 +: 4] != 4'd0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx != 0 && all_zero) return 7'b1111111;
`endif
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   // One clock edge; inputs are held across the edge and the expected pins after it are queued.
   task automatic step(input string nm);
      exp_t e;
      int   idx;
      @(posedge clk);
      #1;
      e.name = nm;
      if (reset) begin
         e.an = 4'b1110; e.sg = 7'b1000000; e.dp = 1'b1;
         k = 0; e_snap = '0; e_dps = '0;
      end else begin
         idx  = (k / RD) % 4;
         e.an = ~(4'b0001 << idx);
         e.sg = exp_seg(e_snap, idx);
         e.dp = ~e_dps[idx];
         k++;
         if (bus.load) begin
            e_snap = bus.digits;
            e_dps  = bus.dp_in;
         end
      end
      q.push_back(e);
   endtask

   task automatic steps(input int n, input string nm);
      for (int i = 0; i < n; i++) step(nm);
   endtask

   task automatic load_pulse(input logic [15:0] d, input logic [3:0] dpi, input string nm);
      bus.digits = d; bus.dp_in = dpi; bus.load = 1'b1;
      step(nm);
      bus.load = 1'b0;
   endtask

   // Directed literal check queued for the next edge, on top of the scan expectation.
   task automatic step_lit(input logic [3:0] an, input logic [6:0] sg, input logic dpv, input string nm);
      exp_t e;
      step(nm);
      e.an = an; e.sg = sg; e.dp = dpv; e.name = {nm, "_lit"};
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (bus.anode !== e.an || bus.seg !== e.sg || bus.dp !== e.dp) begin
            errors++;
            $display("FAIL %s: got anode=%b seg=%b dp=%b, want anode=%b seg=%b dp=%b (t=%0t)",
                     e.name, bus.anode, bus.seg, bus.dp, e.an, e.sg, e.dp, $time);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; bus.load = 1'b1; bus.digits = 16'h9999; bus.dp_in = 4'hF;
      step_lit(4'b1110, 7'b1000000, 1'b1, "reset0");
      bus.load = 1'b0;
      step_lit(4'b1110, 7'b1000000, 1'b1, "reset1");
      reset = 1'b0;

      // Digit 0 lit for edges 1..4, index hits 1 at edge 4, anode moves at edge 5
      steps(3, "idle_d0");
      step_lit(4'b1110, 7'b1000000, 1'b1, "idle_d0_last");
      step_lit(4'b1101, 7'b1000000, 1'b1, "idle_d1_first");
      steps(11, "idle_scan");

      load_pulse(16'h1234, 4'b0000, "load1234");
      steps(17, "scan1234");

      bus.digits = 16'h5678;
      steps(16, "hold1234");
      load_pulse(16'h5678, 4'b0000, "load5678");
      steps(17, "scan5678");

      load_pulse(16'h00A9, 4'b0010, "load00A9");
      steps(17, "scan00A9");

      // Reset in the middle of digit 2 with 1234 latched; simultaneous load is dropped
      load_pulse(16'h1234, 4'b0000, "preload1234");
      while (((k / RD) % 4) != 2) step("seek_d2");
      step("in_d2");
      reset = 1'b1; bus.digits = 16'h9999; bus.dp_in = 4'hF; bus.load = 1'b1;
      step_lit(4'b1110, 7'b1000000, 1'b1, "midscan_reset");
      reset = 1'b0; bus.load = 1'b0;
      steps(16, "post_reset");

      // Load on the edge where index wraps 2->3: digit3 must show 9 immediately, never 5
      load_pulse(16'h5678, 4'b0000, "preload5678");
      while ((k % (4 * RD)) != (3 * RD - 1)) step("seek_wrap3");
      bus.digits = 16'h9000; bus.load = 1'b1;
      step("wrap_load");
      bus.load = 1'b0;
      step_lit(4'b0111, 7'b0010000, 1'b1, "wrap_d3_new");
      steps(RD - 1, "wrap_d3_rest");
      steps(12, "scan9000");

      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
